// File: rtl/osc_sample_rx_pkg.sv
// Shared types and helpers for the oscillator sample receiver.
// The voltage sample width matches the fast-domain synth bus.
package osc_sample_rx_pkg;

  localparam int VOLT_W = 16;

  typedef logic [VOLT_W-1:0] volt_t;
  typedef logic [7:0]        rx_cnt_t;

  localparam rx_cnt_t CNT_MAX = 8'hFF;

  // Increment that sticks at the top of the range instead of wrapping
  function automatic rx_cnt_t sat_inc(input rx_cnt_t c);
    return (c == CNT_MAX) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/osc_sample_rx_cdc_sync2.sv
// N-stage single-bit synchroniser for bringing a level from another clock
// domain into clk. All stages reset to 0.
module cdc_sync2 #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous level through the flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/osc_sample_rx.sv
// Slow-domain receiver for oscillator voltage samples arriving from the fast
// synth clock. The data-valid strobe is synchronised and edge-detected; on the
// edge the (already stable) voltage bus is captured into a small FIFO that the
// downstream consumer drains with valid/ready.
// Optional build macro OSC_RX_STATS_EN adds saturating overflow and
// ready-while-empty counters (ovf_cnt, udf_cnt).
module osc_sample_rx
  import osc_sample_rx_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int SYNC_FF = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  volt_t   v_async,
  input  logic    dv_async,
  output volt_t   out_data,
  output logic    out_valid,
  input  logic    out_ready,
  output logic    overflow
`ifdef OSC_RX_STATS_EN
  ,
  output rx_cnt_t ovf_cnt,
  output rx_cnt_t udf_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic             dv_sync;
  logic             dv_d1;
  logic             capture;
  logic             full;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  volt_t            mem [DEPTH];

  cdc_sync2 #(
    .STAGES (SYNC_FF)
  ) u_dv_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dv_async),
    .q     (dv_sync)
  );

  // Delayed copy of the synchronised strobe for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dv_d1 <= 1'b0;
    else        dv_d1 <= dv_sync;
  end

  // One capture per strobe no matter how long it stays high. v_async is
  // sampled without synchronisation: the sender holds it stable around the strobe.
  assign capture   = dv_sync & ~dv_d1;
  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // When full, a same-cycle pop frees the slot the capture needs
  assign push      = capture & (~full | pop);

  // Head entry is presented directly from the array; zero while empty
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Storage array; contents are don't-care until a pointer/count makes them live
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= v_async;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // One-cycle pulse when a capture is dropped because there is no room
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else        overflow <= capture & full & ~pop;
  end

`ifdef OSC_RX_STATS_EN
  // Saturating event counters, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else begin
      if (capture & full & ~pop)  ovf_cnt <= sat_inc(ovf_cnt);
      if (out_ready & ~out_valid) udf_cnt <= sat_inc(udf_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_osc_sample_rx.sv
// Self-checking bench for osc_sample_rx. A queue-based model predicts the
// FIFO contents from strobe timing; outputs are compared every falling edge,
// plus directed literal checks for the key scenarios. Covers OSC_RX_STATS_EN
// when that macro is defined.
module tb_osc_sample_rx;
  import osc_sample_rx_pkg::*;

  localparam int DEPTH   = 4;
  localparam int SYNC_FF = 2;

  logic    clk       = 1'b0;
  logic    rst_n     = 1'b0;
  volt_t   v_async   = '0;
  logic    dv_async  = 1'b0;
  logic    out_ready = 1'b0;
  volt_t   out_data;
  logic    out_valid;
  logic    overflow;
`ifdef OSC_RX_STATS_EN
  rx_cnt_t ovf_cnt;
  rx_cnt_t udf_cnt;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  volt_t mq[$];
  bit    hist [0:SYNC_FF+1];
  bit    exp_ovf;
  int    exp_ovfc;
  int    exp_udfc;
  int    pushes   = 0;
  int    ovf_seen = 0;
  bit    m_cap;
  bit    m_pop;
  bit    prod_done;
  volt_t got[$];
  int    base_push;
  int    base_ovf;

  always #5 clk = ~clk;

  osc_sample_rx #(
    .DEPTH   (DEPTH),
    .SYNC_FF (SYNC_FF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .v_async   (v_async),
    .dv_async  (dv_async),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
`ifdef OSC_RX_STATS_EN
    ,
    .ovf_cnt   (ovf_cnt),
    .udf_cnt   (udf_cnt)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_edge();
    @(posedge clk);
    #2;
  endtask

  // One strobe: bus and valid rise together, valid stays high for high_clks
  task automatic applyStimulus(input volt_t v, input int high_clks, input int low_clks);
    v_async  = v;
    dv_async = 1'b1;
    repeat (high_clks) wait_edge();
    dv_async = 1'b0;
    repeat (low_clks) wait_edge();
  endtask

  // Reference model: a strobe level first seen at edge n turns into a push
  // decision at edge n+SYNC_FF; the queue holds what the FIFO should contain.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      foreach (hist[i]) hist[i] = 1'b0;
      exp_ovf  = 1'b0;
      exp_ovfc = 0;
      exp_udfc = 0;
    end else begin
      for (int i = SYNC_FF + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = dv_async;
      m_cap = hist[SYNC_FF] && !hist[SYNC_FF+1];
      m_pop = (mq.size() > 0) && out_ready;
      if (mq.size() == 0 && out_ready && exp_udfc < 255) exp_udfc++;
      if (m_pop) void'(mq.pop_front());
      exp_ovf = 1'b0;
      if (m_cap) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(v_async);
          pushes++;
        end else begin
          exp_ovf = 1'b1;
          if (exp_ovfc < 255) exp_ovfc++;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    checkOutput("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) checkOutput("out_data", out_data, mq[0]);
    else                checkOutput("out_data_idle", out_data, 0);
    checkOutput("overflow", overflow, exp_ovf);
    if (overflow) ovf_seen++;
`ifdef OSC_RX_STATS_EN
    checkOutput("ovf_cnt", ovf_cnt, exp_ovfc);
    checkOutput("udf_cnt", udf_cnt, exp_udfc);
`endif
  end

  initial begin
    repeat (3) wait_edge();
    rst_n = 1'b1;
    wait_edge();
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_overflow", overflow, 0);

    // Single sample latency
    v_async  = 16'h1234;
    dv_async = 1'b1;
    wait_edge();
    checkOutput("lat_edge0", out_valid, 0);
    wait_edge();
    checkOutput("lat_edge1", out_valid, 0);
    wait_edge();
    checkOutput("lat_edge2", out_valid, 1);
    checkOutput("single_data", out_data, 16'h1234);
    dv_async = 1'b0;
    repeat (4) wait_edge();
    checkOutput("single_depth", mq.size(), 1);
    checkOutput("single_still_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_edge();
    out_ready = 1'b0;
    checkOutput("single_popped", out_valid, 0);

    // Burst fill past capacity
    for (int i = 1; i <= 5; i++) applyStimulus(volt_t'(i), 2, 2);
    repeat (4) wait_edge();
    checkOutput("burst_ovf_pulses", ovf_seen, 1);
    checkOutput("burst_depth", mq.size(), 4);
    checkOutput("burst_head", out_data, 16'h0001);
`ifdef OSC_RX_STATS_EN
    checkOutput("burst_ovf_cnt", ovf_cnt, 1);
`endif

    // Full FIFO, capture and pop land on the same edge
    v_async  = 16'h0005;
    dv_async = 1'b1;
    wait_edge();
    wait_edge();
    out_ready = 1'b1;
    wait_edge();
    out_ready = 1'b0;
    checkOutput("fullpop_no_ovf", overflow, 0);
    wait_edge();
    dv_async = 1'b0;
    repeat (3) wait_edge();
    got.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) got.push_back(out_data);
    end
    wait_edge();
    out_ready = 1'b0;
    checkOutput("fullpop_count", got.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) checkOutput("fullpop_order", got[i], i + 2);
    checkOutput("fullpop_ovf_total", ovf_seen, 1);

    // Long strobe yields a single capture
    applyStimulus(16'h00AA, 20, 4);
    checkOutput("long_depth", mq.size(), 1);
    checkOutput("long_data", out_data, 16'h00AA);
    out_ready = 1'b1;
    wait_edge();
    out_ready = 1'b0;
    checkOutput("long_popped", out_valid, 0);

    // Randomised streaming with consumer stalls
    base_push = pushes;
    base_ovf  = ovf_seen;
    prod_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          int h;
          h = $urandom_range(2, 3);
          applyStimulus(volt_t'($urandom), h, 6 - h);
        end
        prod_done = 1'b1;
      end
      begin
        while (!prod_done) begin
          out_ready = ($urandom_range(0, 9) < 6);
          wait_edge();
        end
      end
    join
    out_ready = 1'b1;
    repeat (20) wait_edge();
    out_ready = 1'b0;
    wait_edge();
    checkOutput("stream_pushes", pushes - base_push, 200);
    checkOutput("stream_no_ovf", ovf_seen - base_ovf, 0);
    checkOutput("stream_drained", out_valid, 0);

    // Asynchronous reset with entries queued
    for (int i = 0; i < 3; i++) applyStimulus(volt_t'(16'h0100 + i), 2, 2);
    repeat (3) wait_edge();
    checkOutput("prereset_depth", mq.size(), 3);
    checkOutput("prereset_valid", out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", out_valid, 0);
    checkOutput("async_reset_data", out_data, 0);
    repeat (2) wait_edge();
    rst_n = 1'b1;
    repeat (3) wait_edge();
    checkOutput("postreset_empty", out_valid, 0);
`ifdef OSC_RX_STATS_EN
    checkOutput("postreset_ovf_cnt", ovf_cnt, 0);
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
